qif_neuron_scheduler: RTL
=========================

Name: qif_neuron_scheduler

Overview:
Time-multiplexes one shared QIF neuron update datapath across N_NEURONS virtual neurons. Holds per-neuron membrane state V and drive B in local registers. On each timestep it issues every neuron, in index order, to the datapath over a valid/ready request channel and collects the result. It writes back V and assembles a per-timestep spike vector. Sits between the network-level timestep controller and the QIF update unit.

Parameters:
N_NEURONS, 4, number of virtual neurons sharing the datapath (2..16)
IDX_W, 2, neuron index width, equal to clog2(N_NEURONS)
V_W, 8, width of V and B (two's-complement signed)
V_RESET, -20, reset/initial membrane value loaded into every V register

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-high (asserted = 1) despite the name
step_start  input  1  single-cycle pulse that begins one timestep
cfg_we  input  1  write strobe for per-neuron drive B
cfg_idx  input  IDX_W  neuron index for cfg write
cfg_b  input  V_W  signed drive value
upd_valid  output  1  request to the datapath is valid
upd_ready  input  1  datapath accepts the request
upd_idx  output  IDX_W  neuron index of the request
upd_v  output  V_W  current V of that neuron
upd_b  output  V_W  B of that neuron
res_valid  input  1  datapath result valid (single-cycle)
res_v  input  V_W  updated V from the datapath
res_spike  input  1  spike flag from the datapath
busy  output  1  timestep in progress
step_done  output  1  single-cycle pulse at end of timestep
spike_vec  output  N_NEURONS  spikes of the last completed timestep; bit i = neuron i
proto_err  output  1  sticky; res_valid seen outside WAIT

Behaviour:
- Reset (async, rst_n=1): FSM=IDLE; all V=V_RESET; all B=0; idx=0. Outputs upd_valid=0, busy=0, step_done=0, spike_vec=0, proto_err=0. The shadow spike register is cleared.
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE: step_start=1 -> ISSUE, idx=0, shadow spikes cleared. busy=1 from the next cycle.
- ISSUE: upd_valid=1; upd_idx/upd_v/upd_b driven from the register file at idx and held stable until the handshake. Transfer happens when upd_valid and upd_ready are both high -> WAIT.
- WAIT: upd_valid=0. res_valid=1 -> capture res_v and res_spike -> WRITE. No timeout.
- WRITE: V[idx]<=res_v; shadow[idx]<=res_spike. If idx==N_NEURONS-1 -> DONE, else idx+1 -> ISSUE.
- DONE: step_done=1 for exactly one cycle; spike_vec<=shadow; -> IDLE; busy=0 in IDLE.
- Only one request is outstanding at a time. res_valid in the same cycle as the handshake is not accepted; it is treated as outside WAIT.
- Latency: step_start to first upd_valid = 1 cycle. With upd_ready tied high and res_valid one cycle after the handshake, a timestep takes 3*N_NEURONS+1 cycles from the first ISSUE to the step_done cycle inclusive.
- step_start while busy: ignored, with no queuing.
- cfg_we: accepted in any state; B[cfg_idx]<=cfg_b at the clock edge. upd_b is sampled live during ISSUE. A write to the neuron currently in ISSUE is therefore visible in the payload from the next cycle, but never after the handshake.
- res_valid outside WAIT: ignored for state; proto_err<=1 (sticky until reset).
- spike_vec changes only in DONE and holds between timesteps.
- Reset mid-timestep: immediate return to the reset state. The in-flight request is abandoned and late res_valid is flagged as proto_err only if it arrives after reset release outside WAIT.
- No arithmetic is performed here; V and B are stored and forwarded bit-exact.

Optional Feature:
QIF_SCHED_REFRACTORY_EN. When defined, a neuron whose spike bit in spike_vec is 1 (spiked last timestep) is skipped in ISSUE. ISSUE goes directly to the WRITE step with V[idx]=V_RESET and shadow[idx]=0, and no upd_valid is raised for that index. When undefined, every neuron is issued every timestep.

Test Plan:
- Reset then idle: rst_n pulse -> spike_vec=0, busy=0, upd_valid=0; issue step with echo datapath (res_v=upd_v, res_spike=0) -> upd_v=0xEC (-20) for idx 0..3, step_done 13 cycles after the first ISSUE cycle.
- Back-pressure: upd_ready low for 5 cycles on idx 2 -> upd_valid held high, upd_idx=2, payload stable for all 5 cycles; transfer on the first ready cycle.
- Spike collection: datapath returns res_spike=1 for idx 1 and 3 -> spike_vec=4'b1010 after step_done, unchanged until the next DONE.
- Config: cfg_we with idx 2, b=0x10 while idle, then step -> upd_b=0x10 only when upd_idx=2. A write to idx 0 during busy after idx 0 transferred -> used only in the next step.
- Protocol: res_valid pulsed in IDLE -> proto_err=1, stays 1 across steps; step_start during busy -> no second step_done.
- Refractory (macro defined): neuron 1 spiked -> next step issues only idx 0, 2, 3; V[1]=0xEC and spike_vec[1]=0 after that step.

Source files
------------

// File: rtl/qif_neuron_scheduler.sv
// qif_neuron_scheduler
// Time-multiplexes one shared QIF update datapath across N_NEURONS virtual neurons.
// Per-neuron membrane state V and drive B live in local registers. On each timestep
// every neuron is issued in index order over a valid/ready request channel, the result
// is written back to V and the per-neuron spike flags are gathered into spike_vec.
//
// Note: rst_n is an asynchronous, ACTIVE-HIGH reset despite its name.
//
// Optional build macro: QIF_SCHED_REFRACTORY_EN
//   When defined, a neuron that spiked in the last completed timestep is not issued.
//   Its V is reloaded with V_RESET and its spike bit is cleared for the new timestep.
//   When undefined, every neuron is issued every timestep.

module qif_neuron_scheduler #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned V_W       = 8,
    parameter int          V_RESET   = -20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_start,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [V_W-1:0]       cfg_b,
    output logic                 upd_valid,
    input  logic                 upd_ready,
    output logic [IDX_W-1:0]     upd_idx,
    output logic [V_W-1:0]       upd_v,
    output logic [V_W-1:0]       upd_b,
    input  logic                 res_valid,
    input  logic [V_W-1:0]       res_v,
    input  logic                 res_spike,
    output logic                 busy,
    output logic                 step_done,
    output logic [N_NEURONS-1:0] spike_vec,
    output logic                 proto_err
);

    localparam logic [V_W-1:0]   VResetVal = V_W'(V_RESET);
    localparam logic [IDX_W-1:0] IdxLast   = IDX_W'(N_NEURONS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StWrite,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Per-neuron register file
    logic [V_W-1:0] v_q [N_NEURONS];
    logic [V_W-1:0] b_q [N_NEURONS];

    logic [IDX_W-1:0]     idx_q;
    logic [N_NEURONS-1:0] shadow_q;
    logic [N_NEURONS-1:0] spike_vec_q;
    logic [V_W-1:0]       res_v_q;
    logic                 res_spike_q;
    logic                 proto_err_q;

    // High while the neuron at idx_q is being skipped for refractoriness
    logic skip;

`ifdef QIF_SCHED_REFRACTORY_EN
    assign skip = (state_q == StIssue) && spike_vec_q[idx_q];
`else
    assign skip = 1'b0;
`endif

    logic last_idx;
    assign last_idx = (idx_q == IdxLast);

    // FSM state register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (step_start) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (skip) begin
                    state_d = StWrite;
                end else if (upd_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (res_valid) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                state_d = last_idx ? StDone : StIssue;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; the payload is driven live from the register file at idx_q
    always_comb begin
        upd_valid = (state_q == StIssue) && !skip;
        busy      = (state_q != StIdle);
        step_done = (state_q == StDone);
        upd_idx   = idx_q;
        upd_v     = v_q[idx_q];
        upd_b     = b_q[idx_q];
        spike_vec = spike_vec_q;
        proto_err = proto_err_q;
    end

    // Neuron index: restarts at step begin, advances after each write-back
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            idx_q <= '0;
        end else if (state_q == StIdle && step_start) begin
            idx_q <= '0;
        end else if (state_q == StWrite && !last_idx) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    // Result capture; a skipped neuron takes the reset value and no spike
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            res_v_q     <= VResetVal;
            res_spike_q <= 1'b0;
        end else if (state_q == StWait && res_valid) begin
            res_v_q     <= res_v;
            res_spike_q <= res_spike;
        end else if (skip) begin
            res_v_q     <= VResetVal;
            res_spike_q <= 1'b0;
        end
    end

    // Membrane state write-back
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                v_q[i] <= VResetVal;
            end
        end else if (state_q == StWrite) begin
            v_q[idx_q] <= res_v_q;
        end
    end

    // Drive configuration, writable in any state
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                b_q[i] <= '0;
            end
        end else if (cfg_we) begin
            b_q[cfg_idx] <= cfg_b;
        end
    end

    // Shadow spike vector built up during the timestep
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            shadow_q <= '0;
        end else if (state_q == StIdle && step_start) begin
            shadow_q <= '0;
        end else if (state_q == StWrite) begin
            shadow_q[idx_q] <= res_spike_q;
        end
    end

    // Published spike vector, only updated when a timestep completes
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            spike_vec_q <= '0;
        end else if (state_q == StDone) begin
            spike_vec_q <= shadow_q;
        end
    end

    // Sticky protocol error: a result arriving when none is outstanding
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            proto_err_q <= 1'b0;
        end else if (res_valid && state_q != StWait) begin
            proto_err_q <= 1'b1;
        end
    end

endmodule
